// File: rtl/wb_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_port_arbiter_pkg
//  Description : Shared types for the register-file write-port arbiter.
//                - arb_state_t : arbiter state encoding (IDLE / PEND / FORCE)
//                - wb_entry_t  : buffered long-latency result {rd, data, live}
//                  at the default 32-bit / 32-register configuration. The top
//                  re-declares the same layout at its own parameter widths.
//  Revision    : 1.0  initial release
// ============================================================================
package wb_port_arbiter_pkg;

    localparam int WB_WORD_SIZE = 32;
    localparam int WB_NUM_REGS  = 32;
    localparam int WB_REG_SEL   = $clog2(WB_NUM_REGS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // FIFO empty
        PEND  = 2'd1,   // FIFO holds at least one entry
        FORCE = 2'd2    // head is drained this cycle, pipeline stalled
    } arb_state_t;

    typedef struct packed {
        logic [WB_REG_SEL-1:0]   rd;
        logic [WB_WORD_SIZE-1:0] data;
        logic                    live;   // cleared when a younger pipe write hits rd
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_port_arbiter_if
//  Description : Bundles the writeback-stage request, the long-latency result
//                port and the register-file write port.
//                slave  : arbiter side (requests in, rf write / status out)
//                master : requester / environment side
//  Ports       : pipe_reg_write, pipe_rd, pipe_write_data   (writeback stage)
//                lu_valid, lu_ready, lu_rd, lu_data          (long-latency unit)
//                rf_we, rf_rd, rf_wd                         (register file)
//                pipe_stall, pending_count                   (status)
//  Revision    : 1.0  initial release
// ============================================================================
interface wb_port_arbiter_if #(
    parameter int WORD_SIZE  = 32,
    parameter int REG_SEL    = 5,
    parameter int FIFO_DEPTH = 2
);
    localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);

    logic                 pipe_reg_write;
    logic [REG_SEL-1:0]   pipe_rd;
    logic [WORD_SIZE-1:0] pipe_write_data;
    logic                 lu_valid;
    logic                 lu_ready;
    logic [REG_SEL-1:0]   lu_rd;
    logic [WORD_SIZE-1:0] lu_data;
    logic                 rf_we;
    logic [REG_SEL-1:0]   rf_rd;
    logic [WORD_SIZE-1:0] rf_wd;
    logic                 pipe_stall;
    logic [c_cnt_w-1:0]   pending_count;

    modport slave (
        input  pipe_reg_write, pipe_rd, pipe_write_data,
        input  lu_valid, lu_rd, lu_data,
        output lu_ready,
        output rf_we, rf_rd, rf_wd,
        output pipe_stall, pending_count
    );

    modport master (
        output pipe_reg_write, pipe_rd, pipe_write_data,
        output lu_valid, lu_rd, lu_data,
        input  lu_ready,
        input  rf_we, rf_rd, rf_wd,
        input  pipe_stall, pending_count
    );

endinterface
`default_nettype wire

// File: rtl/wb_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_result_fifo
//  Description : Small circular FIFO of buffered long-latency results. Every
//                stored entry whose rd matches i_squash_rd has its live bit
//                cleared while i_squash_en is high.
//  Ports       : clk, rst                  clock / async active-high reset
//                i_push, i_push_entry      enqueue at tail
//                i_pop                     dequeue head
//                i_squash_en, i_squash_rd  clear live bits matching rd
//                o_head                    entry at head (valid when !o_empty)
//                o_full, o_empty, o_count  occupancy
//  Revision    : 1.0  initial release
// ============================================================================
module wb_result_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter int  REG_SEL = WB_REG_SEL,
    parameter type ENTRY_T = wb_entry_t
) (
    input  wire logic                           clk,
    input  wire logic                           rst,
    input  wire logic                           i_push,
    input  ENTRY_T                              i_push_entry,
    input  wire logic                           i_pop,
    input  wire logic                           i_squash_en,
    input  wire logic [REG_SEL-1:0]             i_squash_rd,
    output ENTRY_T                              o_head,
    output logic                                o_full,
    output logic                                o_empty,
    output logic [$clog2(DEPTH+1)-1:0]          o_count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    ENTRY_T               r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]   r_count;

    // The push target slot is always free, so the squash on that slot is
    // irrelevant; the pushed entry arrives with its live bit already resolved.
    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_slot
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_mem[i] <= '0;
                end else if (i_push && (r_wr_ptr == c_ptr_w'(i))) begin
                    r_mem[i] <= i_push_entry;
                end else if (i_squash_en && (r_mem[i].rd == i_squash_rd)) begin
                    r_mem[i].live <= 1'b0;
                end
            end
        end
    endgenerate

    // Depth is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == c_cnt_w'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_port_arbiter
//  Description : Shares the single register-file write port between the
//                in-order writeback path (priority) and the long-latency
//                result port. Long-latency results are buffered and drained
//                on idle port cycles; a starving head forces a one-cycle
//                pipeline stall so it can drain.
//  Ports       : clk  - clock, all state on the rising edge
//                rst  - asynchronous active-high reset
//                bus  - wb_port_arbiter_if.slave: writeback request, lu
//                       result handshake, rf write port, pipe_stall,
//                       pending_count
//  Revision    : 1.0  initial release
// ============================================================================
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int WORD_SIZE  = WB_WORD_SIZE,
    parameter int NUM_REGS   = WB_NUM_REGS,
    parameter int REG_SEL    = $clog2(NUM_REGS),
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_WAIT   = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    wb_port_arbiter_if.slave   bus
);

    localparam int c_cnt_w  = $clog2(FIFO_DEPTH + 1);
    localparam int c_wait_w = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [c_wait_w-1:0] c_wait_max = c_wait_w'(MAX_WAIT - 1);

    typedef struct packed {
        logic [REG_SEL-1:0]   rd;
        logic [WORD_SIZE-1:0] data;
        logic                 live;
    } entry_t;

    arb_state_t             r_state;
    arb_state_t             w_state_next;
    logic [c_wait_w-1:0]    r_wait_cnt;
    logic [c_wait_w-1:0]    w_wait_next;

    entry_t                 w_head;
    entry_t                 w_push_entry;
    logic                   w_full;
    logic                   w_empty;
    logic [c_cnt_w-1:0]     w_count;

    logic                   w_pipe_req;
    logic                   w_lu_xfer;
    logic                   w_pipe_grant;
    logic                   w_bypass;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_rf_we;
    logic [REG_SEL-1:0]     w_rf_rd;
    logic [WORD_SIZE-1:0]   w_rf_wd;

    // x0 is never written, so a pipe write to x0 does not claim the port.
    assign w_pipe_req = bus.pipe_reg_write && (bus.pipe_rd != '0);
    // Ready comes from the registered full flag, before any same-cycle pop.
    assign w_lu_xfer  = bus.lu_valid && !w_full;

    // ------------------------------------------------------------------
    // Port grant
    // ------------------------------------------------------------------
    always_comb begin
        w_rf_we      = 1'b0;
        w_rf_rd      = w_head.rd;
        w_rf_wd      = w_head.data;
        w_pop        = 1'b0;
        w_pipe_grant = 1'b0;
        w_bypass     = 1'b0;

        if (r_state == FORCE) begin
            w_pop   = !w_empty;
            w_rf_we = !w_empty && w_head.live;
        end else if (w_pipe_req) begin
            w_pipe_grant = 1'b1;
            w_rf_we      = 1'b1;
            w_rf_rd      = bus.pipe_rd;
            w_rf_wd      = bus.pipe_write_data;
        end else if (!w_empty) begin
            // A squashed head still dequeues, it just never writes.
            w_pop   = 1'b1;
            w_rf_we = w_head.live;
        end else if (w_lu_xfer && (bus.lu_rd != '0)) begin
            w_bypass = 1'b1;
            w_rf_we  = 1'b1;
            w_rf_rd  = bus.lu_rd;
            w_rf_wd  = bus.lu_data;
        end
    end

    // Results to x0 are accepted and dropped. An entry enqueued alongside a
    // granted pipe write to the same rd is already stale.
    assign w_push             = w_lu_xfer && (bus.lu_rd != '0) && !w_bypass;
    assign w_push_entry.rd    = bus.lu_rd;
    assign w_push_entry.data  = bus.lu_data;
    assign w_push_entry.live  = !(w_pipe_grant && (bus.pipe_rd == bus.lu_rd));

    wb_result_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .REG_SEL (REG_SEL),
        .ENTRY_T (entry_t)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .i_squash_en  (w_pipe_grant),
        .i_squash_rd  (bus.pipe_rd),
        .o_head       (w_head),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_count      (w_count)
    );

    // ------------------------------------------------------------------
    // FSM and head wait counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_push) begin
                    w_state_next = PEND;
                end
            end
            PEND: begin
                if (w_pop && !w_push && (w_count == c_cnt_w'(1))) begin
                    w_state_next = IDLE;
                end else if (!w_pop && (r_wait_cnt == c_wait_max)) begin
                    w_state_next = FORCE;
                end
            end
            FORCE: begin
                // FORCE always dequeues exactly one entry.
                if (w_push || (w_count != c_cnt_w'(1))) begin
                    w_state_next = PEND;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_wait_next = r_wait_cnt;
        if (w_empty || w_pop) begin
            w_wait_next = '0;
        end else if (r_wait_cnt != c_wait_max) begin
            w_wait_next = r_wait_cnt + c_wait_w'(1);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.lu_ready      = !w_full;
    assign bus.rf_we         = w_rf_we;
    assign bus.rf_rd         = w_rf_rd;
    assign bus.rf_wd         = w_rf_wd;
    assign bus.pipe_stall    = (r_state == FORCE);
    assign bus.pending_count = w_count;

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_port_arbiter
//  Description : Self-checking bench for wb_port_arbiter. A queue-based
//                reference model predicts each cycle's register-file write
//                and status outputs; predicted writes go to a scoreboard that
//                a negedge monitor pops whenever the DUT asserts rf_we.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wb_port_arbiter;

    localparam int WS    = 32;
    localparam int NR    = 32;
    localparam int RS    = 5;
    localparam int DEPTH = 2;
    localparam int MW    = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_port_arbiter_if #(.WORD_SIZE(WS), .REG_SEL(RS), .FIFO_DEPTH(DEPTH)) bus ();

    wb_port_arbiter #(
        .WORD_SIZE (WS),
        .NUM_REGS  (NR),
        .REG_SEL   (RS),
        .FIFO_DEPTH(DEPTH),
        .MAX_WAIT  (MW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: buffered results in arrival order.
    typedef struct {
        logic [RS-1:0] rd;
        logic [WS-1:0] data;
        bit            live;
    } ment_t;
    typedef struct {
        logic [RS-1:0] rd;
        logic [WS-1:0] data;
    } wr_t;

    ment_t         mq[$];
    int            m_age;     // cycles the current head has waited undrained
    bit            m_force;   // this cycle is a forced drain
    wr_t           exp_q[$];
    bit            e_valid;
    bit            e_ready;
    bit            e_stall;
    int            e_count;
    logic [WS-1:0] m_rf [NR];
    logic [WS-1:0] d_rf [NR];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        m_age   = 0;
        m_force = 0;
    endtask

    task automatic expect_write(input logic [RS-1:0] rd, input logic [WS-1:0] data);
        wr_t w;
        w.rd = rd;
        w.data = data;
        exp_q.push_back(w);
        m_rf[rd] = data;
    endtask

    // One cycle of the port-sharing rules.
    task automatic model_step(input bit pr, input logic [RS-1:0] prd, input logic [WS-1:0] pwd,
                              input bit lv, input logic [RS-1:0] lrd, input logic [WS-1:0] ld);
        bit    xfer, popped, pipe_g, bypass, had_entries;
        ment_t h, n;
        e_stall     = m_force;
        e_ready     = (mq.size() < DEPTH);
        e_count     = mq.size();
        xfer        = lv && e_ready;
        popped      = 0;
        pipe_g      = 0;
        bypass      = 0;
        had_entries = (mq.size() > 0);

        if (m_force) begin
            h = mq.pop_front();
            popped = 1;
            if (h.live) expect_write(h.rd, h.data);
        end else if (pr && prd != 0) begin
            pipe_g = 1;
            expect_write(prd, pwd);
            foreach (mq[i]) if (mq[i].rd == prd) mq[i].live = 0;
        end else if (mq.size() > 0) begin
            h = mq.pop_front();
            popped = 1;
            if (h.live) expect_write(h.rd, h.data);
        end else if (xfer && lrd != 0) begin
            bypass = 1;
            expect_write(lrd, ld);
        end

        if (xfer && lrd != 0 && !bypass) begin
            n.rd = lrd;
            n.data = ld;
            n.live = !(pipe_g && prd == lrd);
            mq.push_back(n);
        end

        // A head that sits MAX_WAIT cycles without draining is forced next.
        if (had_entries && !popped) m_age++;
        else m_age = 0;
        m_force = (m_age == MW);
    endtask

    task automatic cycle(input bit pr, input logic [RS-1:0] prd, input logic [WS-1:0] pwd,
                         input bit lv, input logic [RS-1:0] lrd, input logic [WS-1:0] ld);
        @(posedge clk);
        #1;
        bus.pipe_reg_write  = pr;
        bus.pipe_rd         = prd;
        bus.pipe_write_data = pwd;
        bus.lu_valid        = lv;
        bus.lu_rd           = lrd;
        bus.lu_data         = ld;
        model_step(pr, prd, pwd, lv, lrd, ld);
        e_valid = 1;
    endtask

    task automatic idle();
        cycle(0, '0, '0, 0, '0, '0);
    endtask

    // Monitor: status checks each driven cycle, scoreboard pop on every write.
    always @(negedge clk) begin
        if (e_valid && !rst) begin
            check("lu_ready", 64'(bus.lu_ready), 64'(e_ready));
            check("pipe_stall", 64'(bus.pipe_stall), 64'(e_stall));
            check("pending_count", 64'(bus.pending_count), 64'(e_count));
            if (bus.rf_we) begin
                d_rf[bus.rf_rd] = bus.rf_wd;
                if (exp_q.size() == 0) begin
                    check("unexpected_rf_we", 64'(1), 64'(0));
                end else begin
                    wr_t w;
                    w = exp_q.pop_front();
                    check("rf_rd", 64'(bus.rf_rd), 64'(w.rd));
                    check("rf_wd", 64'(bus.rf_wd), 64'(w.data));
                end
            end
            check("missing_rf_we", 64'(exp_q.size()), 64'(0));
            exp_q.delete();
        end
    end

    bit            pr, lv, hold, stall_now;
    logic [RS-1:0] prd, lrd;
    logic [WS-1:0] pwd, ld;

    initial begin
        for (int i = 0; i < NR; i++) begin
            m_rf[i] = '0;
            d_rf[i] = '0;
        end
        e_valid = 0;
        rst = 1'b1;
        bus.pipe_reg_write = 0; bus.pipe_rd = '0; bus.pipe_write_data = '0;
        bus.lu_valid = 0; bus.lu_rd = '0; bus.lu_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_lu_ready", 64'(bus.lu_ready), 64'(1));
        check("reset_pipe_stall", 64'(bus.pipe_stall), 64'(0));
        check("reset_pending", 64'(bus.pending_count), 64'(0));
        check("reset_rf_we", 64'(bus.rf_we), 64'(0));
        #1 rst = 1'b0;

        // Bypass on an empty FIFO.
        cycle(0, '0, '0, 1, 5'd5, 32'hDEADBEEF);
        @(negedge clk);
        check("bypass_we", 64'(bus.rf_we), 64'(1));
        check("bypass_rd", 64'(bus.rf_rd), 64'(5));
        check("bypass_wd", 64'(bus.rf_wd), 64'hDEADBEEF);
        check("bypass_pending", 64'(bus.pending_count), 64'(0));

        // Pipe owns the port; two results buffer, the third is refused.
        cycle(1, 5'd3, 32'h0A, 1, 5'd7, 32'h70);
        cycle(1, 5'd3, 32'h0B, 1, 5'd8, 32'h80);
        cycle(1, 5'd3, 32'h0C, 1, 5'd9, 32'h90);
        @(negedge clk);
        check("full_lu_ready", 64'(bus.lu_ready), 64'(0));
        check("full_pending", 64'(bus.pending_count), 64'(2));
        idle();
        @(negedge clk);
        check("drain1_rd", 64'(bus.rf_rd), 64'(7));
        idle();
        @(negedge clk);
        check("drain2_rd", 64'(bus.rf_rd), 64'(8));
        idle();
        idle();

        // Forced drain under continuous pipe writes.
        cycle(1, 5'd3, 32'h100, 1, 5'd10, 32'hAA);
        for (int k = 1; k <= 6; k++) begin
            cycle(1, 5'd3, 32'(k), 0, '0, '0);
            @(negedge clk);
            check("force_stall", 64'(bus.pipe_stall), 64'(k == 5));
            if (k == 5) begin
                check("force_we", 64'(bus.rf_we), 64'(1));
                check("force_rd", 64'(bus.rf_rd), 64'(10));
            end
        end
        idle();

        // Squash: a younger pipe write to x9 kills the buffered one.
        cycle(1, 5'd3, 32'h1, 1, 5'd9, 32'h11);
        cycle(1, 5'd9, 32'h22, 0, '0, '0);
        cycle(0, '0, '0, 0, '0, '0);
        @(negedge clk);
        check("squash_pending", 64'(bus.pending_count), 64'(1));
        check("squash_we", 64'(bus.rf_we), 64'(0));
        idle();
        @(negedge clk);
        check("squash_rf9", 64'(d_rf[9]), 64'h22);

        // x0 handling.
        cycle(0, '0, '0, 1, 5'd0, 32'h55);
        @(negedge clk);
        check("x0_lu_ready", 64'(bus.lu_ready), 64'(1));
        check("x0_rf_we", 64'(bus.rf_we), 64'(0));
        idle();
        @(negedge clk);
        check("x0_pending", 64'(bus.pending_count), 64'(0));
        cycle(1, 5'd3, 32'h2, 1, 5'd12, 32'h77);
        cycle(1, 5'd0, 32'h99, 0, '0, '0);
        @(negedge clk);
        check("x0_drain_we", 64'(bus.rf_we), 64'(1));
        check("x0_drain_rd", 64'(bus.rf_rd), 64'(12));
        check("x0_drain_wd", 64'(bus.rf_wd), 64'h77);
        idle();

        // Asynchronous reset while FORCE with two entries.
        cycle(1, 5'd3, 32'h1, 1, 5'd13, 32'h13);
        cycle(1, 5'd3, 32'h2, 1, 5'd14, 32'h14);
        for (int k = 0; k < 4; k++) cycle(1, 5'd3, 32'(k), 0, '0, '0);
        @(negedge clk);
        check("pre_rst_stall", 64'(bus.pipe_stall), 64'(1));
        check("pre_rst_pending", 64'(bus.pending_count), 64'(2));
        #1;
        e_valid = 0;
        rst = 1'b1;
        #1;
        check("async_rst_pending", 64'(bus.pending_count), 64'(0));
        check("async_rst_stall", 64'(bus.pipe_stall), 64'(0));
        check("async_rst_ready", 64'(bus.lu_ready), 64'(1));
        model_reset();
        bus.pipe_reg_write = 0;
        bus.lu_valid = 0;
        @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;

        // Randomized traffic; a stalled pipe write is re-presented.
        hold = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!hold) begin
                pr  = ($urandom_range(0, 1) == 1);
                prd = RS'($urandom_range(0, 7));
                pwd = $urandom;
            end
            lv  = ($urandom_range(0, 9) < 4);
            lrd = RS'($urandom_range(0, 7));
            ld  = $urandom;
            stall_now = m_force;
            cycle(pr, prd, pwd, lv, lrd, ld);
            hold = stall_now && pr;
        end
        repeat (10) idle();
        @(negedge clk);
        for (int i = 0; i < NR; i++) check($sformatf("rf_x%0d", i), 64'(d_rf[i]), 64'(m_rf[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
